// File: rtl/comp_pkg.sv
// comp_pkg: shared FSM encoding and nibble geometry for the sequential comparator
package comp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;
endpackage

// File: rtl/comp4b.sv
// comp4b: combinational 4-bit nibble magnitude comparator
// ports: a, b nibble operands; gt = a > b; eq = a == b
module comp4b
    import comp_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             gt,
    output logic             eq
);
    assign gt = a > b;
    assign eq = a == b;
endmodule

// File: rtl/comp16b_seq.sv
// comp16b_seq: multi-cycle 16-bit magnitude compare through one shared 4-bit slice, MSB nibble first
// ports: clk, rst (sync, active-high); start/a/b request; busy, done pulse, gt/lt/eq held result
// optional: define COMP16B_SEQ_SIGNED_EN for a two's-complement compare
module comp16b_seq
    import comp_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic        gt,
    output logic        lt,
    output logic        eq
);
`ifdef COMP16B_SEQ_SIGNED_EN
    // offset-binary: flipping the sign bit makes the unsigned walk order signed values
    localparam logic [15:0] FLIP = 16'h8000;
`else
    localparam logic [15:0] FLIP = 16'h0000;
`endif
    state_t      state, state_n;
    logic [15:0] ra, rb;
    logic [1:0]  idx;
    logic        decided, ngt, neq, nlt, diff, fin;
    comp4b u_nib (
        .a  (ra[{idx, 2'b00} +: NIB_W]),
        .b  (rb[{idx, 2'b00} +: NIB_W]),
        .gt (ngt),
        .eq (neq)
    );
    always_comb begin
        nlt     = !ngt && !neq;
        // only the first (most significant) difference may set the result
        diff    = !decided && !neq;
        fin     = (EARLY_EXIT && diff) || idx == 2'd0;
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (fin ? DONE : RUN) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
        if (rst) begin
            ra      <= '0;
            rb      <= '0;
            idx     <= 2'(NIBBLES - 1);
            decided <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else if (state == IDLE && start) begin
            ra      <= a ^ FLIP;
            rb      <= b ^ FLIP;
            idx     <= 2'(NIBBLES - 1);
            decided <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else if (state == RUN) begin
            if (diff) begin
                gt      <= ngt;
                lt      <= nlt;
                decided <= 1'b1;
            end
            if (fin && !decided && neq)
                eq <= 1'b1;
            if (!fin)
                idx <= idx - 2'd1;
        end
    end
endmodule

// File: tb/tb_comp16b_seq.sv
// tb_comp16b_seq: directed + random checks of both EARLY_EXIT builds against an arithmetic reference
module tb_comp16b_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] a, b;
    logic        busy1, done1, gt1, lt1, eq1;
    logic        busy0, done0, gt0, lt0, eq0;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    comp16b_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1)
    );
    comp16b_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [2:0] ref_flags(input logic [15:0] x, input logic [15:0] y);
`ifdef COMP16B_SEQ_SIGNED_EN
        return {$signed(x) > $signed(y), $signed(x) < $signed(y), x == y};
`else
        return {x > y, x < y, x == y};
`endif
    endfunction

    // early-exit done cycle: 5 - (index of most significant differing nibble), 5 if equal
    function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
        for (int k = 3; k >= 0; k--)
            if ((((x ^ y) >> (4 * k)) & 16'hF) != 16'h0) return 5 - k;
        return 5;
    endfunction

    task automatic run(input logic [15:0] va, input logic [15:0] vb, input bit hold);
        logic [2:0] ef;
        int         l1;
        ef = ref_flags(va, vb);
        l1 = ref_lat(va, vb);
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!hold || c == 5) start = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            if (c == 1) begin
                chk("clear1", {gt1, lt1, eq1}, 3'b000);
                chk("clear0", {gt0, lt0, eq0}, 3'b000);
            end
            chk("done1", done1, c == l1);
            chk("busy1", busy1, c <= l1);
            chk("done0", done0, c == 5);
            chk("busy0", busy0, c <= 5);
            if (c == l1) chk("flags1", {gt1, lt1, eq1}, ef);
            if (c == 5) chk("flags0", {gt0, lt0, eq0}, ef);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold", {gt1, lt1, eq1, gt0, lt0, eq0}, {ef, ef});
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset1", {busy1, done1, gt1, lt1, eq1}, 5'b0);
        chk("reset0", {busy0, done0, gt0, lt0, eq0}, 5'b0);
        rst = 1'b0;
        run(16'h1234, 16'h1234, 1'b0);
        run(16'h9000, 16'h1000, 1'b0);
        run(16'h1FF0, 16'h2001, 1'b0);
        run(16'h00A5, 16'h00A7, 1'b0);
        run(16'hFFFF, 16'h0001, 1'b0);
        run(16'h0001, 16'hFFFF, 1'b0);
        run(16'h8000, 16'h7FFF, 1'b0);
        run(16'h4321, 16'h4321, 1'b1);
        // reset in cycle 2 of an equal compare aborts it without a done pulse
        @(negedge clk);
        start = 1'b1;
        a = 16'h1234;
        b = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort1", {busy1, done1, gt1, lt1, eq1}, 5'b0);
        chk("rst_abort0", {busy0, done0, gt0, lt0, eq0}, 5'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done", {done1, done0, busy1, busy0}, 4'b0);
        end
        run(16'h1234, 16'h1234, 1'b0);
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[15:4], rb[3:0]};
                2: rb = {ra[15:8], rb[7:0]};
                default: ;
            endcase
            run(ra, rb, 1'b0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
